// File: rtl/servo_decode.sv
// servo_decode: measures the high time of an RC/servo pulse in ticks of
// TICK_CYCLES clocks and maps it to an 8-bit position. It flags loss of
// signal after TIMEOUT_TICKS ticks without an accepted pulse.
// Optional build macro: SERVO_DECODE_GLITCH_FILTER_EN adds a 4-sample glitch
// filter after the synchronizer.
module servo_decode #(
   parameter int TICK_CYCLES    = 195,
   parameter int OFFSET_TICKS   = 256,
   parameter int MAX_HIGH_TICKS = 640,
   parameter int TIMEOUT_TICKS  = 6400
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pwm_in,
   output logic [7:0] val,
   output logic       new_val,
   output logic       valid,
   output logic       err
);

   localparam int CW = 16;
   localparam int PW = $clog2(TICK_CYCLES + 1);

   localparam logic [1:0] WAIT_LOW = 2'd0;
   localparam logic [1:0] IDLE     = 2'd1;
   localparam logic [1:0] HIGH     = 2'd2;

   logic          s1_q, s2_q;
   logic          lvl_q, lvl_d;
   logic          rise_q, rise_d, fall_q, fall_d;
   logic [1:0]    state_q, state_d;
   logic [PW-1:0] pre_q, pre_d, gpre_q, gpre_d;
   logic [CW-1:0] hi_q, hi_d, gap_q, gap_d;
   logic [7:0]    val_q, val_d;
   logic          new_val_q, new_val_d, valid_q, valid_d, err_q, err_d;

   // High time in ticks -> position, clamped to 0..255 without wrap-around.
   function automatic logic [7:0] ticks_to_val(input logic [CW-1:0] t);
      logic [CW-1:0] d;
      if (t <= CW'(OFFSET_TICKS)) return 8'd0;
      d = t - CW'(OFFSET_TICKS);
      if (d > CW'(255)) return 8'hFF;
      return d[7:0];
   endfunction

`ifdef SERVO_DECODE_GLITCH_FILTER_EN
   logic [1:0] fcnt_q, fcnt_d;

   // Filtered level follows the synchronized input only after it has
   // disagreed for 4 consecutive samples.
   always_comb begin
      lvl_d  = lvl_q;
      fcnt_d = '0;
      if (s2_q != lvl_q) begin
         if (fcnt_q == 2'd3) lvl_d = s2_q;
         else                fcnt_d = fcnt_q + 2'd1;
      end
   end

   // Filter run-length counter.
   always_ff @(posedge clk) begin
      if (rst) fcnt_q <= '0;
      else     fcnt_q <= fcnt_d;
   end
`else
   // Unfiltered build: the level is the synchronized sample itself.
   always_comb lvl_d = s2_q;
`endif

   // Edges compare the new level with the previously registered one.
   always_comb begin
      rise_d = ~lvl_q & lvl_d;
      fall_d = lvl_q & ~lvl_d;
   end

   // Measurement FSM, tick prescalers, gap timeout and output strobes.
   always_comb begin
      state_d   = state_q;
      pre_d     = pre_q;
      hi_d      = hi_q;
      val_d     = val_q;
      valid_d   = valid_q;
      new_val_d = 1'b0;
      err_d     = 1'b0;
      gpre_d    = gpre_q + PW'(1);
      gap_d     = gap_q;

      if (gpre_q == PW'(TICK_CYCLES - 1)) begin
         gpre_d = '0;
         if (gap_q < CW'(TIMEOUT_TICKS)) gap_d = gap_q + CW'(1);
      end

      case (state_q)
         WAIT_LOW: if (!lvl_q) state_d = IDLE;
         IDLE: begin
            if (rise_q) begin
               state_d = HIGH;
               pre_d   = '0;
               hi_d    = '0;
            end
         end
         HIGH: begin
            if (fall_q) begin
               state_d = IDLE;
               if (hi_q <= CW'(MAX_HIGH_TICKS)) begin
                  val_d     = ticks_to_val(hi_q);
                  new_val_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end else if (pre_q == PW'(TICK_CYCLES - 1)) begin
               pre_d = '0;
               if (hi_q < CW'(MAX_HIGH_TICKS + 1)) hi_d = hi_q + CW'(1);
            end else begin
               pre_d = pre_q + PW'(1);
            end
         end
         default: state_d = WAIT_LOW;
      endcase

      // An accepted pulse beats a coincident timeout.
      if (new_val_d) begin
         gap_d   = '0;
         gpre_d  = '0;
         valid_d = 1'b1;
      end else if (gap_d >= CW'(TIMEOUT_TICKS)) begin
         valid_d = 1'b0;
      end
   end

   // State registers; the input chain resets high so a pulse in progress at
   // reset release is never seen as a fresh rising edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q      <= 1'b1;
         s2_q      <= 1'b1;
         lvl_q     <= 1'b1;
         rise_q    <= 1'b0;
         fall_q    <= 1'b0;
         state_q   <= WAIT_LOW;
         pre_q     <= '0;
         hi_q      <= '0;
         gpre_q    <= '0;
         gap_q     <= '0;
         val_q     <= '0;
         new_val_q <= 1'b0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         s1_q      <= pwm_in;
         s2_q      <= s1_q;
         lvl_q     <= lvl_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         state_q   <= state_d;
         pre_q     <= pre_d;
         hi_q      <= hi_d;
         gpre_q    <= gpre_d;
         gap_q     <= gap_d;
         val_q     <= val_d;
         new_val_q <= new_val_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
      end
   end

   assign val     = val_q;
   assign new_val = new_val_q;
   assign valid   = valid_q;
   assign err     = err_q;

endmodule

// File: tb/tb_servo_decode.sv
// Bench for servo_decode (default build, no glitch filter) with scaled-down
// timing parameters so that every scenario fits in a short run.
module tb_servo_decode;

   localparam int T    = 2;
   localparam int OFF  = 8;
   localparam int MAXT = 300;
   localparam int TMO  = 400;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pwm_in = 1'b0;
   logic [7:0] val;
   logic       new_val, valid, err;

   int n_chk = 0, n_pass = 0;
   int nv_seen = 0, err_seen = 0;
   int exp_nv = 0, exp_err = 0;
   int model_val = 0;
   int model_valid = 0;

   servo_decode #(
      .TICK_CYCLES(T), .OFFSET_TICKS(OFF),
      .MAX_HIGH_TICKS(MAXT), .TIMEOUT_TICKS(TMO)
   ) dut (
      .clk(clk), .rst(rst), .pwm_in(pwm_in),
      .val(val), .new_val(new_val), .valid(valid), .err(err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (new_val) nv_seen++;
      if (err) err_seen++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Drive one high pulse of len cycles followed by low_cycles of low time,
   // checking the 4-cycle result timing. Called on a negedge.
   task automatic pulse(input int len, input int low_cycles);
      int ticks, ev;
      bit acc;
      ticks = len / T;
      acc   = (ticks <= MAXT);
      if (ticks <= OFF) ev = 0;
      else if (ticks - OFF > 255) ev = 255;
      else ev = ticks - OFF;
      pwm_in = 1'b1;
      repeat (len) @(negedge clk);
      pwm_in = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         if (i == 4) begin
            check("new_val", int'(new_val), int'(acc));
            check("err", int'(err), int'(!acc));
            if (acc) begin
               model_val   = ev;
               model_valid = 1;
            end
            check("val", int'(val), model_val);
            check("valid", int'(valid), model_valid);
         end else if (i == 3 || i == 5) begin
            check("strobe_quiet", int'({new_val, err}), 0);
         end
      end
      if (acc) exp_nv++;
      else     exp_err++;
      repeat (low_cycles) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_val", int'(val), 0);
      check("rst_flags", int'({new_val, valid, err}), 0);
      rst = 1'b0;
      repeat (10) @(negedge clk);

      // Directed: mid position, both clamp ends, max legal, too long.
      pulse(273, 20);          // 136 ticks -> 128
      pulse(17, 20);           // 8 ticks -> 0
      pulse(11, 20);           // 5 ticks, below offset -> 0
      pulse(527, 20);          // 263 ticks -> clamp 255
      pulse(273, 20);
      pulse(2 * MAXT + 1, 20); // exactly max legal -> 255
      pulse(273, 20);
      pulse(2 * MAXT + 3, 20); // one tick too long -> err, val held
      pulse(3, 20);            // 3-cycle glitch -> accepted, val 0

      // Randomized pulses including some too-long ones.
      for (int k = 0; k < 20; k++)
         pulse(2 * $urandom_range(0, 330) + 1, $urandom_range(5, 40));

      // Timeout: valid drops TMO*T cycles after the last acceptance.
      pulse(273, 0);
      repeat (794) @(negedge clk);
      check("valid_before_tmo", int'(valid), 1);
      repeat (10) @(negedge clk);
      check("valid_after_tmo", int'(valid), 0);
      check("val_held", int'(val), 128);
      model_valid = 0;
      pulse(2 * MAXT + 5, 10); // rejected after timeout keeps valid low
      pulse(41, 10);           // 20 ticks -> 12, valid back

      // Reset in the middle of a pulse aborts it silently.
      pwm_in = 1'b1;
      repeat (30) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_val", int'(val), 0);
      check("midrst_valid", int'(valid), 0);
      model_val = 0;
      model_valid = 0;
      repeat (30) @(negedge clk);
      pwm_in = 1'b0;
      repeat (12) @(negedge clk);
      check("midrst_no_nv", nv_seen, exp_nv);
      check("midrst_no_err", err_seen, exp_err);

      // Pulse already high across reset release is not measured.
      pwm_in = 1'b1;
      rst = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      pwm_in = 1'b0;
      repeat (12) @(negedge clk);
      check("relhigh_no_nv", nv_seen, exp_nv);
      check("relhigh_val", int'(val), 0);
      pulse(273, 20);

      check("total_new_val", nv_seen, exp_nv);
      check("total_err", err_seen, exp_err);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/servo_decode.md
SERVO_DECODE -- requirements
Module: servo_decode

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 195: clk cycles per measurement tick (about 3.9 us at 50 MHz).
REQ-002 SHALL have parameter OFFSET_TICKS, default 256: tick count that maps to val 0 (1.0 ms).
REQ-003 SHALL have parameter MAX_HIGH_TICKS, default 640: longest legal high time (about 2.5 ms).
REQ-004 SHALL have parameter TIMEOUT_TICKS, default 6400: ticks with no accepted pulse before loss (about 25 ms).
REQ-005 SHALL have port clk, input, 1 bit: the single system clock.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port pwm_in, input, 1 bit: asynchronous servo/RC pulse input.
REQ-008 SHALL have port val, output, 8 bits: last decoded position.
REQ-009 SHALL have port new_val, output, 1 bit: one-cycle strobe when val updates.
REQ-010 SHALL have port valid, output, 1 bit: high while pulses arrive within the timeout.
REQ-011 SHALL have port err, output, 1 bit: one-cycle strobe when a too-long pulse is rejected.

Function
REQ-012 SHALL pass pwm_in through a 2-FF synchronizer; edge detection SHALL compare the synchronized sample with its previous value.
REQ-013 SHALL implement states WAIT_LOW, IDLE and HIGH.
- WAIT_LOW -> IDLE: on synchronized low.
- IDLE -> HIGH: on rising edge.
- HIGH -> IDLE: on falling edge.
REQ-014 On entry to HIGH, SHALL clear the prescaler and hi_ticks.
- Prescaler counts 0..TICK_CYCLES-1 and wraps.
- A tick SHALL occur on the wrap.
REQ-015 hi_ticks SHALL increment once per tick while in HIGH and SHALL saturate at MAX_HIGH_TICKS+1.
REQ-016 On falling edge with hi_ticks <= MAX_HIGH_TICKS:
- val SHALL become min(max(hi_ticks-OFFSET_TICKS, 0), 255).
- new_val SHALL pulse high on the next clk cycle.
- valid SHALL be set.
REQ-017 On falling edge with hi_ticks > MAX_HIGH_TICKS:
- val SHALL be unchanged.
- err SHALL pulse for one cycle.
- new_val SHALL stay low.
REQ-018 Latency SHALL be exactly 4 clk cycles from the pwm_in falling transition to new_val high: 2 sync stages, 1 edge, 1 register.
REQ-019 A free-running gap counter SHALL count ticks and clear on every accepted pulse.
- On reaching TIMEOUT_TICKS, valid SHALL drop.
- val SHALL be held.
- The counter SHALL saturate there.
REQ-020 If timeout and an accepted falling edge occur in the same cycle, the accepted pulse SHALL win: valid stays 1 and the counter clears.
REQ-021 The subtraction and clamp SHALL use unsigned arithmetic at least 11 bits wide.
- No wrap-around SHALL be permitted.
- The tick and gap counters SHALL be at least 13 bits wide.

Reset
REQ-022 While rst is high at a clk edge, the block SHALL set:
- val=0, new_val=0, valid=0, err=0;
- all counters=0;
- state=WAIT_LOW.
REQ-023 A pulse already high when rst falls SHALL NOT be measured; measurement SHALL begin only after pwm_in is seen low.
REQ-024 Asserting rst mid-pulse SHALL abort the measurement with no new_val or err strobe.

Configuration
REQ-025 With macro SERVO_DECODE_GLITCH_FILTER_EN defined:
- A glitch filter SHALL follow the synchronizer.
- The filtered level SHALL change only after 4 consecutive equal synchronized samples.
- Latency (REQ-018) SHALL become 7 cycles.
- High pulses shorter than 4 cycles SHALL be ignored.
REQ-026 Without SERVO_DECODE_GLITCH_FILTER_EN, no filter SHALL be instantiated and REQ-018 latency SHALL apply.

Verification
REQ-027 1.5 ms pulse (75000 cycles) at 20 ms period -> hi_ticks 384, val=128, new_val once per period, valid=1.
REQ-028 Pulses of 1.0 ms, 0.8 ms and 2.0 ms -> val=0, 0, 255 respectively (clamp at both ends).
REQ-029 3.0 ms pulse -> err one cycle, new_val low, val keeps prior value.
REQ-030 Pulses stop after a valid one -> valid drops 6400*195 = 1,248,000 cycles after that pulse's acceptance.
REQ-031 pwm_in high during and after rst release, then falling -> no strobe; the next full 1.5 ms pulse -> val=128.
REQ-032 Filter build, 3-cycle high glitch -> no state change; non-filter build, same glitch -> new_val with val=0.
